// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiply that time-shares the external combinational ALU.
// Inputs: clk, rst_n (async, active low), start, op_a, op_b, alu_result.
// Outputs: busy, done (one-cycle pulse), product (low WIDTH bits), alu_a, alu_b, alu_ctrl.
// Optional ALU_MUL_EARLY_EXIT_EN: leave SHIFT once no multiplier bits remain.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [3:0] ALU_ADD = 4'b0110,
  parameter logic [3:0] ALU_SLL = 4'b0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d;
  logic [CW-1:0] count_q, count_d;
  logic last;
`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last = count_q == CW'(WIDTH - 1) || mplier_q[WIDTH-1:1] == '0;
`else
  assign last = count_q == CW'(WIDTH - 1);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (start ? ADD : IDLE) :
              state_q == ADD   ? SHIFT :
              state_q == SHIFT ? (last ? DONE : ADD) : IDLE;
  always_comb begin
    busy     = state_q != IDLE;
    done     = state_q == DONE;
    product  = product_q;
    alu_a    = state_q == ADD ? acc_q : state_q == SHIFT ? mcand_q : '0;
    alu_b    = state_q == ADD ? (mplier_q[0] ? mcand_q : '0) : state_q == SHIFT ? WIDTH'(1) : '0;
    alu_ctrl = state_q == SHIFT ? ALU_SLL : ALU_ADD;
  end
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    if (state_q == IDLE && start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
      count_d  = '0;
    end
    if (state_q == ADD) acc_d = alu_result;
    if (state_q == SHIFT) begin
      mcand_d  = alu_result;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
    end
    if (state_q == DONE) product_d = acc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vector table plus multi-cycle corner sequences.
module tb_alu_mul_sequencer;
  logic clk = 0, rst_n = 0, start = 0, busy, done;
  logic [31:0] op_a = 0, op_b = 0, product, alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [31:0] a, b, p;} vec_t;
  vec_t v[9];
  always #5 clk = ~clk;
  always_comb
    alu_result = alu_ctrl == 4'b0110 ? alu_a + alu_b : alu_ctrl == 4'b0100 ? alu_a << alu_b[4:0] : '0;
  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [31:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    return 2 * (m + 1) + 1;
`else
    return 65;
`endif
  endfunction
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    op_a = a;
    op_b = b;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] ep);
    int n = 0;
    bit ok = 1;
    @(negedge clk);
    issue(a, b);
    op_a = $urandom;
    op_b = $urandom;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        if (!busy || alu_ctrl !== (n % 2 ? 4'b0110 : 4'b0100)) ok = 0;
        if (n == 1 && (alu_a !== 0 || alu_b !== (b[0] ? a : 0))) ok = 0;
        if (n % 2 == 0 && alu_b !== 1) ok = 0;
      end
    end while (!done && n < 300);
    chk({nm, " latency"}, n, exp_lat(b));
    chk({nm, " alu drive"}, 32'(ok), 1);
    chk({nm, " busy in done"}, 32'(busy), 1);
    @(negedge clk);
    chk({nm, " done pulse"}, 32'(done), 0);
    chk({nm, " busy after"}, 32'(busy), 0);
    chk({nm, " product"}, product, ep);
  endtask
  initial begin
    int n, dones, last_done, l1, l2;
    v[0] = '{32'd7, 32'd6, 32'd42};
    v[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    v[2] = '{32'h00010000, 32'h00010000, 32'h00000000};
    v[3] = '{32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1};
    v[4] = '{32'd0, 32'd1234, 32'd0};
    v[5] = '{32'd1234, 32'd0, 32'd0};
    v[6] = '{32'd9, 32'd1, 32'd9};
    v[7] = '{32'd3, 32'h80000000, 32'h80000000};
    v[8] = '{32'h12345678, 32'h00000100, 32'h34567800};
    #12;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset product", product, 0);
    chk("reset alu_a", alu_a, 0);
    chk("reset alu_b", alu_b, 0);
    chk("reset alu_ctrl", 32'(alu_ctrl), 32'h6);
    rst_n = 1;
    for (int i = 0; i < 9; i++) run_mul($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].p);
    l1 = exp_lat(32'd6);
    l2 = exp_lat(32'd11);
    @(negedge clk);
    issue(32'd7, 32'd6);
    n = 0;
    dones = 0;
    last_done = 0;
    while (n < l1 + l2 + 2) begin
      @(negedge clk);
      n++;
      if (done) begin
        dones++;
        last_done = n;
      end
      if (n == 3 || n == l1) issue(32'd100, 32'd100);
      else if (n == l1 + 1) begin
        chk("ignored start product", product, 32'd42);
        chk("ignored start idle", 32'(busy), 0);
        issue(32'd13, 32'd11);
      end
    end
    chk("b2b done count", dones, 2);
    chk("b2b second done cycle", last_done, l1 + 1 + l2);
    chk("b2b product", product, 32'd143);
    @(negedge clk);
    issue(32'd3, 32'h80000000);
    n = 0;
    dones = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (done) dones++;
    end
    rst_n = 0;
    #1;
    chk("async rst busy", 32'(busy), 0);
    chk("async rst product", product, 0);
    chk("async rst done", 32'(done), 0);
    chk("no done before rst", dones, 0);
    @(negedge clk);
    rst_n = 1;
    run_mul("after rst", 32'd7, 32'd6, 32'd42);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
